// File: rtl/keypad_matrix_emu_pkg.sv
// keypad_pkg: shared types and constants for the keypad matrix emulator.
// State encoding, key field positions and bounce LFSR parameters.
package keypad_pkg;

  typedef enum logic [2:0] {
    KP_IDLE,
    KP_PRESS_BOUNCE,
    KP_HOLD,
    KP_RELEASE_BOUNCE,
    KP_DONE
  } kp_emu_state_t;

  localparam int KEY_ROW_MSB = 3;
  localparam int KEY_ROW_LSB = 2;
  localparam int KEY_COL_MSB = 1;
  localparam int KEY_COL_LSB = 0;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // x^8+x^6+x^5+x^4+1 -> state bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(
    input logic [7:0] q
  );
    return {q[6:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/keypad_matrix_emu_if.sv
// keypad_matrix_emu_if: press request and matrix sense bundle.
// master = scanner/bench side, slave = emulator side.
interface keypad_matrix_emu_if #(
  parameter int HOLD_W = 16
);

  logic [3:0]        row_select;
  logic [3:0]        key_code;
  logic [HOLD_W-1:0] hold_cycles;
  logic              press_req;
  logic [3:0]        col_out;
  logic              busy;
  logic              done;
  logic              contact;

  modport master (
    output row_select,
    output key_code,
    output hold_cycles,
    output press_req,
    input  col_out,
    input  busy,
    input  done,
    input  contact
  );

  modport slave (
    input  row_select,
    input  key_code,
    input  hold_cycles,
    input  press_req,
    output col_out,
    output busy,
    output done,
    output contact
  );

endinterface

// File: rtl/keypad_matrix_emu_lfsr.sv
// bounce_lfsr: 8-bit Fibonacci LFSR that models contact chatter.
// Holds its value when en is low; reset loads the fixed seed.
module bounce_lfsr
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= LFSR_SEED;
    end else if (en) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/keypad_matrix_emu.sv
// keypad_matrix_emu: passive 4x4 keypad matrix driven by a row scanner.
// Define KEYPAD_EMU_BOUNCE_EN to add press/release contact bounce.
module keypad_matrix_emu
  import keypad_pkg::*;
#(
  parameter int BOUNCE_CYCLES = 8,
  parameter int HOLD_W        = 16
) (
  input logic               clk,
  input logic               rst,
  keypad_matrix_emu_if.slave kp
);

  if (BOUNCE_CYCLES < 1) begin : g_bad_bounce
    $error("BOUNCE_CYCLES must be at least 1");
  end

  kp_emu_state_t     state;
  kp_emu_state_t     state_n;
  logic [3:0]        key_q;
  logic [3:0]        key_n;
  logic [HOLD_W-1:0] cnt;
  logic [HOLD_W-1:0] cnt_n;
  logic [HOLD_W-1:0] hold_clamp;
  logic              accept;
  logic              contact;
  logic              bounce_bit;
  logic [3:0]        col;

  assign hold_clamp = (kp.hold_cycles == '0)
                    ? HOLD_W'(1) : kp.hold_cycles;
  // DONE is not busy, but a request there is still dropped
  assign accept = (state == KP_IDLE) & kp.press_req;

`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int BW = $clog2(BOUNCE_CYCLES + 1);

  logic [BW-1:0]     bcnt;
  logic [BW-1:0]     bcnt_n;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_n;
  logic [7:0]        lfsr;
  logic              lfsr_en;
  logic              lfsr_unused;

  assign lfsr_en = (state == KP_PRESS_BOUNCE) |
                   (state == KP_RELEASE_BOUNCE);
  assign bounce_bit  = lfsr[0];
  assign lfsr_unused = ^lfsr[7:1];

  bounce_lfsr u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (lfsr_en),
    .q   (lfsr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt   <= '0;
      hold_q <= '0;
    end else begin
      bcnt   <= bcnt_n;
      hold_q <= hold_n;
    end
  end
`else
  assign bounce_bit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= KP_IDLE;
      key_q <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      key_q <= key_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    key_n   = key_q;
    cnt_n   = cnt;
`ifdef KEYPAD_EMU_BOUNCE_EN
    bcnt_n  = bcnt;
    hold_n  = hold_q;
`endif
    unique case (state)
      KP_IDLE: begin
        if (accept) begin
          key_n = kp.key_code;
`ifdef KEYPAD_EMU_BOUNCE_EN
          hold_n  = hold_clamp;
          bcnt_n  = BW'(BOUNCE_CYCLES);
          state_n = KP_PRESS_BOUNCE;
`else
          cnt_n   = hold_clamp;
          state_n = KP_HOLD;
`endif
        end
      end
`ifdef KEYPAD_EMU_BOUNCE_EN
      KP_PRESS_BOUNCE: begin
        if (bcnt == BW'(1)) begin
          cnt_n   = hold_q;
          state_n = KP_HOLD;
        end else begin
          bcnt_n = bcnt - BW'(1);
        end
      end
`endif
      KP_HOLD: begin
        if (cnt == HOLD_W'(1)) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
          bcnt_n  = BW'(BOUNCE_CYCLES);
          state_n = KP_RELEASE_BOUNCE;
`else
          state_n = KP_DONE;
`endif
        end else begin
          cnt_n = cnt - HOLD_W'(1);
        end
      end
`ifdef KEYPAD_EMU_BOUNCE_EN
      KP_RELEASE_BOUNCE: begin
        if (bcnt == BW'(1)) begin
          state_n = KP_DONE;
        end else begin
          bcnt_n = bcnt - BW'(1);
        end
      end
`endif
      KP_DONE: begin
        state_n = KP_IDLE;
      end
      default: begin
        state_n = KP_IDLE;
      end
    endcase
  end

  always_comb begin
    contact = 1'b0;
    kp.busy = 1'b0;
    kp.done = 1'b0;
    unique case (state)
      KP_PRESS_BOUNCE,
      KP_RELEASE_BOUNCE: begin
        contact = bounce_bit;
        kp.busy = 1'b1;
      end
      KP_HOLD: begin
        contact = 1'b1;
        kp.busy = 1'b1;
      end
      KP_DONE: begin
        kp.done = 1'b1;
      end
      default: begin
        contact = 1'b0;
      end
    endcase
  end

  // zero-latency path: row drive reaches the column like a real contact
  always_comb begin
    col = 4'hF;
    if (contact &&
        !kp.row_select[key_q[KEY_ROW_MSB:KEY_ROW_LSB]]) begin
      col[key_q[KEY_COL_MSB:KEY_COL_LSB]] = 1'b0;
    end
  end

  assign kp.col_out = col;
  assign kp.contact = contact;

endmodule

// File: tb/tb_keypad_matrix_emu.sv
// tb_keypad_matrix_emu: scoreboard bench for keypad_matrix_emu.
// Per-cycle expectations queued by stimulus, checked by a monitor.
module tb_keypad_matrix_emu;

  localparam int B  = 8;
  localparam int HW = 16;
`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int BB = B;
`else
  localparam int BB = 0;
`endif

  typedef struct packed {
    logic [7:0] tid;
    logic       b;
    logic       d;
    logic       c;
    logic [3:0] col;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  logic [7:0] lm  = 8'hA5;
  logic [7:0] tid = 8'd0;

  always #5 clk = ~clk;

  keypad_matrix_emu_if #(.HOLD_W(HW)) kp();

  keypad_matrix_emu #(
    .BOUNCE_CYCLES (B),
    .HOLD_W        (HW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp)
  );

  function automatic logic [7:0] lnext(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [3:0] ecol(
    input logic c, input logic [3:0] key, input logic [3:0] rs
  );
    logic [3:0] r;
    r = 4'hF;
    if (c && !rs[key[3:2]]) r[key[1:0]] = 1'b0;
    return r;
  endfunction

  function automatic logic [3:0] rowpat(input int pat, input int k);
    case (pat)
      0: case (k % 4)
           0: return 4'b1110;
           1: return 4'b1101;
           2: return 4'b1011;
           default: return 4'b0111;
         endcase
      1: return 4'b0111;
      2: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic push(
    input logic b, input logic d, input logic c, input logic [3:0] col
  );
    exp_t e;
    e.tid = tid;
    e.b = b;
    e.d = d;
    e.c = c;
    e.col = col;
    q.push_back(e);
  endtask

  task automatic press(
    input logic [3:0] key, input logic [15:0] hold,
    input int pat, input bit keep, input int abort_k
  );
    int h;
    int total;
    logic [3:0] rs;
    logic c;
    h = (hold == 16'd0) ? 1 : int'(hold);
    total = 2 * BB + h + 1;
    kp.press_req = 1'b1;
    kp.key_code = key;
    kp.hold_cycles = hold;
    kp.row_select = rowpat(pat, 0);
    push(1'b0, 1'b0, 1'b0, 4'hF);
    for (int k = 1; k <= total; k++) begin
      @(posedge clk);
      #1;
      if (keep) kp.key_code = 4'h3;
      else kp.press_req = 1'b0;
      rs = rowpat(pat, k);
      kp.row_select = rs;
      if (k <= BB || (k > BB + h && k < total)) begin
        c = lm[0];
        lm = lnext(lm);
      end else begin
        c = (k <= BB + h);
      end
      push(k < total, k == total, c, ecol(c, key, rs));
      if (k == abort_k) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        lm = 8'hA5;
        return;
      end
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_vec++;
      if (kp.busy !== e.b || kp.done !== e.d ||
          kp.contact !== e.c || kp.col_out !== e.col) begin
        n_miss++;
        $display("FAIL t%0d cycle: busy/done/contact/col = %b %b %b %b, want %b %b %b %b",
                 e.tid, kp.busy, kp.done, kp.contact, kp.col_out,
                 e.b, e.d, e.c, e.col);
      end
    end else if (kp.busy || kp.done) begin
      n_miss++;
      $display("FAIL unexpected activity: busy=%b done=%b",
               kp.busy, kp.done);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    kp.press_req = 1'b0;
    kp.key_code = 4'h0;
    kp.hold_cycles = '0;
    kp.row_select = 4'hF;
    @(posedge clk);
    #1;
    push(1'b0, 1'b0, 1'b0, 4'hF);
    @(posedge clk);
    #1;
    rst = 1'b0;

    tid = 8'd1;
    press(4'h6, 16'd100, 0, 1'b0, 0);
    tid = 8'd2;
    press(4'hF, 16'd0, 1, 1'b0, 0);
    tid = 8'd3;
    press(4'h9, 16'd5, 3, 1'b1, 0);
    press(4'h3, 16'd5, 3, 1'b0, 0);
    tid = 8'd4;
    press(4'h6, 16'd100, 0, 1'b0, BB + 50);
    press(4'h6, 16'd3, 0, 1'b0, 0);
    tid = 8'd5;
    press(4'h5, 16'd20, 2, 1'b0, 0);
    tid = 8'd6;
    press(4'hA, 16'd20, 3, 1'b0, 0);
    tid = 8'd7;
    push(1'b0, 1'b0, 1'b0, 4'hF);
    @(posedge clk);
    #1;
    @(negedge clk);
    #1;
    n_vec++;
    if (q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
